// File: rtl/homing_sequencer_if.sv
// ----------------------------------------------------------------------------
// homing_sequencer_if
//   Servo command channel between the homing sequencer (master) and the servo
//   PWM bank (slave).
//
//   Handshake: the master raises cmd_valid together with cmd_id/cmd_pos and
//   holds all three stable until it samples cmd_valid & cmd_ready high on a
//   clk edge; that edge is the single transfer of the command. cmd_ready is
//   meaningless while cmd_valid is low, and the slave may drive it either way
//   at any time.
//
//   Signals:
//     cmd_valid  master -> slave  command presented
//     cmd_ready  slave  -> master command accepted this cycle
//     cmd_id     master -> slave  servo index (5 bits)
//     cmd_pos    master -> slave  target position code (8 bits)
// ----------------------------------------------------------------------------
interface homing_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [4:0] cmd_id;
    logic [7:0] cmd_pos;

    modport master (
        output cmd_valid,
        output cmd_id,
        output cmd_pos,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_id,
        input  cmd_pos,
        output cmd_ready
    );
endinterface

// File: rtl/homing_sequencer.sv
// ----------------------------------------------------------------------------
// homing_sequencer
//   On each rising edge of `enable`, sends every servo (0..NUM_SERVOS-1), one
//   at a time, to HOME_POS over the command channel, waiting SETTLE_CYCLES
//   clk cycles after each accepted command. When the last servo has settled,
//   `homed` is raised and held until `enable` drops. Dropping `enable` while
//   a sequence runs aborts it (an in-flight command is still completed).
//
//   Ports:
//     clk        system clock
//     rst        synchronous active-low reset
//     enable     homing request level (clk-synchronous)
//     cmd        command channel, master side (see homing_sequencer_if)
//     busy       sequence in progress
//     homed      all servos homed and settled
//     state_dbg  current FSM state (0 IDLE, 1 ISSUE, 2 SETTLE, 3 DONE)
//
//   All outputs are registered.
// ----------------------------------------------------------------------------
module homing_sequencer #(
    parameter int         NUM_SERVOS    = 18,
    parameter logic [7:0] HOME_POS      = 8'd128,
    parameter int         SETTLE_CYCLES = 2_400_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    homing_sequencer_if.master        cmd,
    output logic                      busy,
    output logic                      homed,
    output logic [1:0]                state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [4:0]  LAST_ID     = 5'(NUM_SERVOS - 1);
    localparam logic [23:0] SETTLE_LOAD = 24'(SETTLE_CYCLES - 1);

    state_t      state_q, state_nx;
    logic [4:0]  index_q, index_nx;
    logic [23:0] cnt_q, cnt_nx;
    logic        valid_q, valid_nx;
    logic [7:0]  pos_q, pos_nx;
    logic        busy_q, busy_nx;
    logic        homed_q, homed_nx;
    logic        abort_q, abort_nx;
    logic        enable_d;
    logic        rise;
    logic        go_idle;

    assign rise = enable & ~enable_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            index_q  <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            pos_q    <= '0;
            busy_q   <= 1'b0;
            homed_q  <= 1'b0;
            abort_q  <= 1'b0;
            enable_d <= 1'b0;
        end else begin
            state_q  <= state_nx;
            index_q  <= index_nx;
            cnt_q    <= cnt_nx;
            valid_q  <= valid_nx;
            pos_q    <= pos_nx;
            busy_q   <= busy_nx;
            homed_q  <= homed_nx;
            abort_q  <= abort_nx;
            enable_d <= enable;
        end
    end

    always_comb begin
        state_nx = state_q;
        index_nx = index_q;
        cnt_nx   = cnt_q;
        valid_nx = valid_q;
        busy_nx  = busy_q;
        homed_nx = homed_q;
        abort_nx = abort_q;
        go_idle  = 1'b0;

        case (state_q)
            IDLE: begin
                valid_nx = 1'b0;
                busy_nx  = 1'b0;
                homed_nx = 1'b0;
                index_nx = '0;
                abort_nx = 1'b0;
                if (rise) begin
                    state_nx = ISSUE;
                    busy_nx  = 1'b1;
                end
            end

            ISSUE: begin
                if (!valid_q) begin
                    // First ISSUE cycle after IDLE: nothing is on the bus yet,
                    // so an abort here can leave without a transfer.
                    if (!enable) begin
                        go_idle = 1'b1;
                    end else begin
                        valid_nx = 1'b1;
                    end
                end else if (cmd.cmd_ready) begin
                    valid_nx = 1'b0;
                    if (abort_q || !enable) begin
                        go_idle = 1'b1;
                    end else begin
                        state_nx = SETTLE;
                        cnt_nx   = SETTLE_LOAD;
                    end
                end else if (!enable) begin
                    // Command already presented: it must complete first.
                    abort_nx = 1'b1;
                end
            end

            SETTLE: begin
                // Abort is checked first so it wins over counter expiry.
                if (!enable) begin
                    go_idle = 1'b1;
                end else if (cnt_q == '0) begin
                    if (index_q == LAST_ID) begin
                        state_nx = DONE;
                        busy_nx  = 1'b0;
                        homed_nx = 1'b1;
                    end else begin
                        // Present the next command on entry so commands are
                        // spaced SETTLE_CYCLES+1 apart with cmd_ready held high.
                        state_nx = ISSUE;
                        index_nx = index_q + 5'd1;
                        valid_nx = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt_q - 24'd1;
                end
            end

            DONE: begin
                busy_nx  = 1'b0;
                homed_nx = 1'b1;
                if (!enable) begin
                    state_nx = IDLE;
                    homed_nx = 1'b0;
                end
            end

            default: begin
                go_idle = 1'b1;
            end
        endcase

        if (go_idle) begin
            state_nx = IDLE;
            valid_nx = 1'b0;
            busy_nx  = 1'b0;
            homed_nx = 1'b0;
            index_nx = '0;
            cnt_nx   = '0;
            abort_nx = 1'b0;
        end

        pos_nx = valid_nx ? HOME_POS : 8'd0;
    end

    assign cmd.cmd_valid = valid_q;
    assign cmd.cmd_id    = index_q;
    assign cmd.cmd_pos   = pos_q;
    assign busy          = busy_q;
    assign homed         = homed_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_homing_sequencer.sv
// ----------------------------------------------------------------------------
// tb_homing_sequencer
//   Directed bench for homing_sequencer with NUM_SERVOS=3, SETTLE_CYCLES=4.
//   A reference model tracks the sequence as "servo being commanded" plus
//   "cycles since last accepted command" and is compared against the DUT on
//   every falling edge; accepted-command ids go through a scoreboard queue.
//   Directed steps add hand-computed latency/spacing/hold expectations.
// ----------------------------------------------------------------------------
module tb_homing_sequencer;

  localparam int         NS = 3;
  localparam int         SC = 4;
  localparam logic [7:0] HP = 8'd128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic busy, homed;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  homing_sequencer_if bus ();

  homing_sequencer #(
    .NUM_SERVOS    (NS),
    .HOME_POS      (HP),
    .SETTLE_CYCLES (SC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .cmd       (bus.master),
    .busy      (busy),
    .homed     (homed),
    .state_dbg (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int hs_total = 0;
  bit cmp_on   = 0;

  logic [4:0] exp_q[$];
  logic [4:0] dut_q[$];
  int         hs_cyc[$];
  int         hs_id_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // DUT-side transfer monitor
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst && bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) begin
      dut_q.push_back(bus.cmd_id);
      hs_cyc.push_back(cyc);
      hs_id_log.push_back(int'(bus.cmd_id));
      hs_total++;
    end
  end

  // ---------------- reference model ----------------
  bit m_valid, m_busy, m_homed, m_abort, m_raise, en_prev;
  int m_id, m_age;

  task automatic stop_model();
    m_busy  = 0;
    m_valid = 0;
    m_homed = 0;
    m_abort = 0;
    m_raise = 0;
    m_id    = 0;
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      stop_model();
      en_prev = 0;
      m_age   = 0;
    end else begin
      if (m_homed) begin
        if (!enable) m_homed = 0;
      end else if (!m_busy) begin
        if (enable && !en_prev) begin
          m_busy  = 1;
          m_id    = 0;
          m_raise = 1;
        end
      end else if (m_valid) begin
        if (!enable) m_abort = 1;
        if (bus.cmd_ready) begin
          exp_q.push_back(5'(m_id));
          m_valid = 0;
          m_age   = 0;
          if (m_abort) stop_model();
        end
      end else if (m_raise) begin
        if (!enable) stop_model();
        else begin
          m_raise = 0;
          m_valid = 1;
        end
      end else begin
        m_age++;
        if (!enable) stop_model();
        else if (m_age == SC) begin
          if (m_id == NS - 1) begin
            m_busy  = 0;
            m_homed = 1;
          end else begin
            m_id++;
            m_valid = 1;
          end
        end
      end
      en_prev = enable;
    end
  end

  // ---------------- scoreboard / per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cmd_valid", bus.cmd_valid, m_valid);
      chk("busy", busy, m_busy);
      chk("homed", homed, m_homed);
      if (m_valid) begin
        chk("cmd_id", bus.cmd_id, m_id);
        chk("cmd_pos", bus.cmd_pos, HP);
      end
      while (dut_q.size() > 0 && exp_q.size() > 0)
        chk("hs_id", dut_q.pop_front(), exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_valid(input int budget, input string name);
    int k = 0;
    while (bus.cmd_valid !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, bus.cmd_valid, 1);
  endtask

  task automatic wait_homed(input int budget, input string name);
    int k = 0;
    while (homed !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, homed, 1);
  endtask

  task automatic wait_hs(input int n, input int budget, input string name);
    int k = 0;
    while (hs_total < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, hs_total, n);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, bus.cmd_valid, 0);
    chk({tag, "_id"}, bus.cmd_id, 0);
    chk({tag, "_pos"}, bus.cmd_pos, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_homed"}, homed, 0);
  endtask

  task automatic chk_seq(input string tag, input int first, input int base);
    chk({tag, "_hs_count"}, hs_total - base, 3);
    if (hs_id_log.size() >= first + 3) begin
      chk({tag, "_id0"}, hs_id_log[first], 0);
      chk({tag, "_id1"}, hs_id_log[first + 1], 1);
      chk({tag, "_id2"}, hs_id_log[first + 2], 2);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int t0, base, first, h;
    bus.cmd_ready = 1'b1;
    enable = 1'b1;
    rst = 1'b0;

    // Reset held with enable already high
    repeat (3) @(negedge clk);
    cmp_on = 1;
    chk_all_zero("rst");
    rst = 1'b1;
    t0 = cyc;
    wait_valid(10, "rel_valid");
    chk("rel_latency", cyc - t0, 2);

    // Reset in the middle of SETTLE
    base = hs_total;
    wait_hs(base + 1, 10, "rel_hs");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("mid_rst");
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal sequence, cmd_ready held high
    t0 = cyc;
    base = hs_total;
    first = hs_id_log.size();
    enable = 1'b1;
    wait_valid(10, "t1_valid");
    chk("t1_latency", cyc - t0, 2);
    wait_homed(100, "t1_homed");
    chk_seq("t1", first, base);
    if (hs_cyc.size() >= first + 3) begin
      chk("t1_gap01", hs_cyc[first + 1] - hs_cyc[first], 5);
      chk("t1_gap12", hs_cyc[first + 2] - hs_cyc[first + 1], 5);
      chk("t1_homed_lat", cyc - hs_cyc[first + 2], 4);
    end
    chk("t1_busy", busy, 0);

    // DONE release
    enable = 1'b0;
    @(negedge clk);
    chk("t5_homed_drop", homed, 0);
    chk("t5_busy", busy, 0);

    // Repeat with backpressure at id 1
    base = hs_total;
    first = hs_id_log.size();
    enable = 1'b1;
    wait_hs(base + 1, 20, "t2_hs0");
    bus.cmd_ready = 1'b0;
    wait_valid(20, "t2_valid1");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t2_hold_valid", bus.cmd_valid, 1);
      chk("t2_hold_id", bus.cmd_id, 1);
      chk("t2_hold_pos", bus.cmd_pos, HP);
    end
    chk("t2_no_hs_while_blocked", hs_total - base, 1);
    bus.cmd_ready = 1'b1;
    wait_homed(100, "t2_homed");
    chk_seq("t2", first, base);

    // Abort during SETTLE
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    base = hs_total;
    wait_hs(base + 1, 20, "t3_hs0");
    repeat (2) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("t3_busy", busy, 0);
    chk("t3_homed", homed, 0);
    chk("t3_valid", bus.cmd_valid, 0);
    base = hs_total;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_idle_valid", bus.cmd_valid, 0);
    end
    chk("t3_no_hs", hs_total - base, 0);
    bus.cmd_ready = 1'b0;
    enable = 1'b1;
    wait_valid(10, "t3_restart_valid");
    chk("t3_restart_id", bus.cmd_id, 0);

    // Abort during ISSUE with the command blocked
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", bus.cmd_valid, 1);
    end
    base = hs_total;
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    chk("t4_hs", hs_total - base, 1);
    chk("t4_valid", bus.cmd_valid, 0);
    chk("t4_busy", busy, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_idle_valid", bus.cmd_valid, 0);
    end
    chk("t4_single_hs", hs_total - base, 1);

    // Transfer and enable falling on the same edge
    bus.cmd_ready = 1'b0;
    enable = 1'b1;
    wait_valid(10, "t7_valid");
    base = hs_total;
    bus.cmd_ready = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk("t7_hs", hs_total - base, 1);
    chk("t7_busy", busy, 0);
    repeat (6) @(negedge clk);
    chk("t7_single_hs", hs_total - base, 1);

    // Settle expiry of the last servo coincides with enable falling
    enable = 1'b1;
    base = hs_total;
    wait_hs(base + 3, 100, "t8_hs3");
    h = hs_cyc[hs_cyc.size() - 1];
    while (cyc < h + 3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("t8_homed", homed, 0);
    chk("t8_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("t8_homed_later", homed, 0);

    chk("sb_exp_left", exp_q.size(), 0);
    chk("sb_dut_left", dut_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/homing_sequencer.md
Name: homing_sequencer

Overview:
- Consumes the `enable` produced by the time-delayed homing enable generator.
- On each rising edge of `enable`, drives every hexapod servo, one at a time, to its home position through a valid/ready command interface to the servo PWM bank.
- Waits a settle time after each accepted command, then asserts `homed`.
- Sits between the basic-behaviour enable logic and the servo controllers.

Parameters:
- NUM_SERVOS, 18, number of servos homed; range 1..32.
- HOME_POS, 8'd128, position code sent to every servo (mid-travel).
- SETTLE_CYCLES, 2_400_000, clk cycles waited after each accepted command (200 ms at 12 MHz); range 1..2^24-1.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-low reset; rst=0 at a clk edge resets the block.
- enable, input, 1, homing request level from the homing enable generator; may be asynchronous to internal events but is clk-synchronous.
- cmd_ready, input, 1, servo bank accepts the command this cycle.
- cmd_valid, output, 1, command presented.
- cmd_id, output, 5, servo index 0..NUM_SERVOS-1.
- cmd_pos, output, 8, target position; always HOME_POS while cmd_valid=1.
- busy, output, 1, sequence in progress.
- homed, output, 1, all servos homed and settled.

Behaviour:
- Reset, when rst=0 at a clk edge:
  - state=IDLE; cmd_valid=0, cmd_id=0, cmd_pos=0, busy=0, homed=0.
  - Servo index=0, settle counter=0, enable_d=0.
- enable_d is `enable` registered once. A rising edge is `enable=1 & enable_d=0`.
- Outputs are registered and change only on clk edges.
- FSM states: IDLE, ISSUE, SETTLE, DONE.
- IDLE:
  - On a rising edge, the next cycle is ISSUE with index=0 and busy=1.
  - Latency from enable going high to the first cmd_valid=1 is 2 clk cycles.
- ISSUE:
  - cmd_valid=1, cmd_id=index, cmd_pos=HOME_POS.
  - cmd_id and cmd_pos stay stable, and cmd_valid stays high, until cmd_valid&cmd_ready is sampled high.
  - On handshake: cmd_valid=0 next cycle, counter loads SETTLE_CYCLES-1, state goes to SETTLE.
- SETTLE:
  - Counter decrements once per cycle. SETTLE lasts exactly SETTLE_CYCLES cycles.
  - At counter=0: if index=NUM_SERVOS-1, go to DONE; else index+1 and go to ISSUE.
  - Commands are therefore spaced by at least SETTLE_CYCLES+1 cycles.
- DONE:
  - homed=1, busy=0.
  - Remains in DONE while enable=1.
  - enable=0 → IDLE next cycle with homed=0.
- Abort when enable=0 during ISSUE or SETTLE:
  - A pending abort flag is set.
  - In ISSUE, cmd_valid must not drop before the handshake. After the handshake completes, go to IDLE instead of SETTLE.
  - In SETTLE, go to IDLE immediately.
  - IDLE on abort: busy=0, homed=0, index=0.
- The abort flag clears on entry to IDLE.
- Re-arm:
  - enable returning high before IDLE is reached does not cancel a pending abort.
  - A fresh rising edge in IDLE restarts from servo 0.
- Enable already high out of reset: enable_d resets to 0, so enable=1 at reset release counts as a rising edge and starts a sequence.
- Simultaneous events:
  - Handshake and enable falling in the same cycle: the handshake counts, then go to IDLE.
  - Counter reaching 0 and enable falling in the same cycle: the abort wins, go to IDLE, homed stays 0.
- Reset mid-operation: the block returns to reset values the next cycle, and cmd_valid drops regardless of handshake.
- cmd_ready is ignored when cmd_valid=0.

Test Plan:
1. Nominal sequence with NUM_SERVOS=3, SETTLE_CYCLES=4, cmd_ready tied 1, enable 0→1:
   - cmd_valid first high 2 cycles later.
   - cmd_id goes 0,1,2, each with cmd_pos=128, handshakes 5 cycles apart.
   - homed=1 four cycles after the last handshake; busy=0.
2. Backpressure: hold cmd_ready=0 for 10 cycles at id=1.
   - cmd_valid=1, cmd_id=1, cmd_pos=128 stay constant throughout.
   - Exactly one handshake per id; total ids = 3.
3. Abort in SETTLE: drop enable during the settle after id=0.
   - IDLE next cycle, busy=0, homed=0, no further cmd_valid.
   - New enable rise → restarts at cmd_id=0.
4. Abort in ISSUE with cmd_ready=0: drop enable while cmd_valid=1.
   - cmd_valid stays 1 until cmd_ready=1; handshake occurs.
   - Then IDLE, with no SETTLE and no next id.
5. DONE release: with homed=1, enable 1→0.
   - homed=0 next cycle.
   - enable 0→1 → full 3-servo sequence repeats.
6. Reset: assert rst=0 mid-SETTLE and at time 0 with enable=1.
   - All outputs zero the next cycle.
   - On release with enable=1, the sequence starts (cmd_valid after 2 cycles).
